// File: rtl/double_gt_arbiter_pkg.sv
// Shared constants and types for the double_gt arbiter slice.
package double_gt_arbiter_pkg;

  localparam int unsigned DBL_W          = 64;
  localparam int unsigned GT_LATENCY_DEF = 2;

  typedef struct packed {
    logic        sign;
    logic [10:0] exp;
    logic [51:0] man;
  } dbl_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned w;
    w = 0;
    while ((64'd1 << w) < 64'(n)) w++;
    return w;
  endfunction

  // Requester index width; a single requester still needs one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n < 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/double_gt.sv
// Pipelined IEEE-754 binary64 a > b; NaN gives 0 and +0/-0 compare equal.
module double_gt
  import double_gt_arbiter_pkg::*;
#(
  parameter int unsigned LATENCY = GT_LATENCY_DEF
) (
  input  logic             clk,
  input  logic [DBL_W-1:0] a,
  input  logic [DBL_W-1:0] b,
  output logic             z
);

  dbl_t               fa, fb;
  logic               a_nan, b_nan, both_zero, gt;
  logic [LATENCY-1:0] z_pipe;

  always_comb begin
    fa        = dbl_t'(a);
    fb        = dbl_t'(b);
    a_nan     = (&fa.exp) && (|fa.man);
    b_nan     = (&fb.exp) && (|fb.man);
    both_zero = ~|{fa.exp, fa.man} && ~|{fb.exp, fb.man};
    gt        = 1'b0;
    if (!(a_nan || b_nan || both_zero)) begin
      // Sign-magnitude ordering: magnitude order flips when both are negative.
      unique case ({fa.sign, fb.sign})
        2'b00:   gt = {fa.exp, fa.man} > {fb.exp, fb.man};
        2'b01:   gt = 1'b1;
        2'b10:   gt = 1'b0;
        default: gt = {fa.exp, fa.man} < {fb.exp, fb.man};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    z_pipe[0] <= gt;
    for (int unsigned k = 1; k < LATENCY; k++) z_pipe[k] <= z_pipe[k-1];
  end

  assign z = z_pipe[LATENCY-1];

endmodule

// File: rtl/double_gt_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first request at or after ptr, wrapping.
module rr_arbiter
  import double_gt_arbiter_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant
);

  logic        found;
  int unsigned idx;

  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned off = 0; off < N; off++) begin
      idx = (32'(ptr) + off) % N;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/double_gt_arbiter.sv
// Shares one double_gt comparator among N requesters with round-robin operand
// acceptance and one outstanding operation per requester.
module double_gt_arbiter
  import double_gt_arbiter_pkg::*;
#(
  parameter int unsigned N          = 4,
  parameter int unsigned GT_LATENCY = GT_LATENCY_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N-1:0]       req_valid,
  output logic [N-1:0]       req_ready,
  input  logic [N*DBL_W-1:0] req_a,
  input  logic [N*DBL_W-1:0] req_b,
  output logic [N-1:0]       res_valid,
  input  logic [N-1:0]       res_ready,
  output logic [N-1:0]       res_z,
  output logic               idle
);

  localparam int unsigned IW = idx_width(N);
  typedef logic [IW-1:0] idx_t;

  logic [N-1:0]          busy, eligible, grant, done_vec, held_vld, held_z, res_hs;
  idx_t                  ptr, g_idx, op_id, done_id;
  logic                  accept, op_vld, gt_z, done;
  logic [DBL_W-1:0]      op_a, op_b;
  logic [GT_LATENCY-1:0] vp_vld;
  idx_t                  vp_id [GT_LATENCY];

  assign eligible = req_valid & ~busy;

  rr_arbiter #(.N(N), .IW(IW)) u_rr (
    .req   (eligible),
    .ptr   (ptr),
    .grant (grant)
  );

  assign req_ready = grant & {N{rst_n}};
  assign accept    = |grant;

  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (grant[i]) g_idx = idx_t'(i);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
      ptr  <= '0;
    end else begin
      busy <= (busy & ~res_hs) | grant;
      if (accept) ptr <= (32'(g_idx) == N - 1) ? '0 : g_idx + idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_vld <= 1'b0;
      op_id  <= '0;
    end else begin
      op_vld <= accept;
      if (accept) op_id <= g_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= req_a[DBL_W*g_idx +: DBL_W];
      op_b <= req_b[DBL_W*g_idx +: DBL_W];
    end
  end

  double_gt #(.LATENCY(GT_LATENCY)) u_gt (
    .clk (clk),
    .a   (op_a),
    .b   (op_b),
    .z   (gt_z)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vp_vld <= '0;
      for (int unsigned k = 0; k < GT_LATENCY; k++) vp_id[k] <= '0;
    end else begin
      vp_vld[0] <= op_vld;
      vp_id[0]  <= op_id;
      for (int unsigned k = 1; k < GT_LATENCY; k++) begin
        vp_vld[k] <= vp_vld[k-1];
        vp_id[k]  <= vp_id[k-1];
      end
    end
  end

  assign done    = vp_vld[GT_LATENCY-1];
  assign done_id = vp_id[GT_LATENCY-1];

  // The result is forwarded straight from the comparator in its completion
  // cycle and captured into the held registers if not consumed right away.
  always_comb begin
    done_vec = '0;
    res_z    = '0;
    for (int unsigned i = 0; i < N; i++) begin
      done_vec[i] = done && (done_id == idx_t'(i));
      res_z[i]    = done_vec[i] ? gt_z : held_z[i];
    end
  end

  assign res_valid = held_vld | done_vec;
  assign res_hs    = res_valid & res_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held_vld <= '0;
      held_z   <= '0;
    end else begin
      held_vld <= res_valid & ~res_ready;
      held_z   <= res_z;
    end
  end

  assign idle = ~|busy & ~op_vld & ~|vp_vld;

endmodule

// File: tb/tb_double_gt_arbiter.sv
// Directed bench for double_gt_arbiter with a scoreboard of expected results.
module tb_double_gt_arbiter;

  localparam int unsigned N = 4;

  localparam logic [63:0] D1   = 64'h3FF0000000000000;
  localparam logic [63:0] D2   = 64'h4000000000000000;
  localparam logic [63:0] D3   = 64'h4008000000000000;
  localparam logic [63:0] DM2  = 64'hC000000000000000;
  localparam logic [63:0] DM3  = 64'hC008000000000000;
  localparam logic [63:0] DNAN = 64'h7FF8000000000000;
  localparam logic [63:0] PZ   = 64'h0000000000000000;
  localparam logic [63:0] NZ   = 64'h8000000000000000;
  localparam logic [63:0] PINF = 64'h7FF0000000000000;
  localparam logic [63:0] DMAX = 64'h7FEFFFFFFFFFFFFF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, res_valid, res_ready, res_z;
  logic [N*64-1:0]  req_a, req_b;
  logic             idle;

  double_gt_arbiter #(.N(N), .GT_LATENCY(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_z     (res_z),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned     idx;
    logic            z;
    longint unsigned acc;
  } exp_t;

  exp_t            sb[$];
  int unsigned     checks = 0;
  int unsigned     passes = 0;
  longint unsigned cyc = 0;

  always @(posedge clk) cyc++;

  function automatic logic ref_gt(input logic [63:0] a, input logic [63:0] b);
    return $bitstoreal(a) > $bitstoreal(b);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Arbitration model and result scoreboard, sampled on the falling edge.
  logic [N-1:0] mbusy, prev_rv, prev_hs, eg;
  int unsigned  mptr;

  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      mbusy   = '0;
      mptr    = 0;
      prev_rv = '0;
      prev_hs = '0;
    end else begin
      eg = '0;
      for (int unsigned o = 0; o < N; o++) begin
        int unsigned j;
        j = (mptr + o) % N;
        if (eg == '0 && req_valid[j] && !mbusy[j]) eg[j] = 1'b1;
      end
      chk("req_ready", req_ready, eg);
      for (int unsigned i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{i, ref_gt(req_a[64*i +: 64], req_b[64*i +: 64]), cyc});
          mbusy[i] = 1'b1;
          mptr     = (i + 1) % N;
        end
      end
      for (int unsigned i = 0; i < N; i++) begin
        int found;
        found = -1;
        for (int k = 0; k < sb.size(); k++) begin
          if (found < 0 && sb[k].idx == i) found = k;
        end
        if (res_valid[i] && !prev_rv[i]) begin
          chk("res_spurious", found >= 0, 1);
          if (found >= 0) begin
            chk("res_latency", cyc - sb[found].acc, 3);
            chk("res_z_first", res_z[i], sb[found].z);
          end
        end
        if (prev_rv[i] && !res_valid[i]) chk("res_dropped", prev_hs[i], 1);
        if (res_valid[i] && res_ready[i]) begin
          mbusy[i] = 1'b0;
          if (found >= 0) begin
            chk("res_z_taken", res_z[i], sb[found].z);
            sb.delete(found);
          end
        end
      end
      prev_rv = res_valid;
      prev_hs = res_valid & res_ready;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acc(input int unsigned i, input string tag);
    int unsigned n;
    n = 0;
    @(negedge clk);
    while (!(req_valid[i] && req_ready[i]) && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk(tag, req_valid[i] & req_ready[i], 1);
  endtask

  task automatic do_op(input int unsigned i, input logic [63:0] a, input logic [63:0] b,
                       input logic ez, input string tag);
    int unsigned n;
    tick();
    req_a[64*i +: 64] = a;
    req_b[64*i +: 64] = b;
    req_valid[i]      = 1'b1;
    wait_acc(i, {tag, "_acc"});
    tick();
    req_valid[i] = 1'b0;
    @(negedge clk);
    chk({tag, "_busy"}, idle, 0);
    n = 1;
    while (!res_valid[i] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_lat"}, n, 3);
    chk({tag, "_z"}, res_z[i], ez);
    @(negedge clk);
    chk({tag, "_idle"}, idle, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n, last, n1, n3;
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = '1;
    req_a     = '0;
    req_b     = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_req_ready", req_ready, 0);
    chk("reset_res_valid", res_valid, 0);
    chk("reset_res_z", res_z, 0);
    chk("reset_idle", idle, 1);
    tick();
    rst_n = 1'b1;

    do_op(0, D3, D2, 1'b1, "single_gt");
    do_op(0, D2, D3, 1'b0, "single_swap");
    do_op(1, DNAN, D1, 1'b0, "nan_a");
    do_op(2, D1, DNAN, 1'b0, "nan_b");
    do_op(0, PZ, NZ, 1'b0, "zeros");
    do_op(3, PINF, DMAX, 1'b1, "inf");
    do_op(1, DM2, DM3, 1'b1, "negatives");

    // Contention from reset with results held.
    tick();
    res_ready = '0;
    rst_n     = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int unsigned i = 0; i < N; i++) begin
      req_a[64*i +: 64] = {$urandom, $urandom};
      req_b[64*i +: 64] = {$urandom, $urandom};
    end
    req_valid = '1;
    for (int unsigned k = 0; k < N; k++) begin
      @(negedge clk);
      chk("cont_order", req_ready, 64'd1 << k);
    end
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("cont_no_reaccept", req_ready, 0);
    end
    chk("cont_all_held", res_valid, 4'hF);
    tick();
    req_valid = '0;
    res_ready = '1;
    @(negedge clk);
    @(negedge clk);
    chk("cont_idle", idle, 1);

    // Backpressure on requester 2.
    tick();
    res_ready[2]      = 1'b0;
    req_a[128 +: 64]  = D3;
    req_b[128 +: 64]  = D1;
    req_valid[2]      = 1'b1;
    wait_acc(2, "bp_acc");
    tick();
    req_a[128 +: 64] = D1;
    req_b[128 +: 64] = D3;
    n = 0;
    @(negedge clk);
    while (!res_valid[2] && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("bp_res_arrives", res_valid[2], 1);
    for (int unsigned k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_valid_hold", res_valid[2], 1);
      chk("bp_z_hold", res_z[2], 1);
      chk("bp_no_ready", req_ready[2], 0);
    end
    tick();
    res_ready[2] = 1'b1;
    @(negedge clk);
    chk("bp_hs_cycle_ready", req_ready[2], 0);
    @(negedge clk);
    chk("bp_reaccept", req_ready[2], 1);
    tick();
    req_valid[2] = 1'b0;
    repeat (5) @(negedge clk);
    chk("bp_idle", idle, 1);

    // Reset one cycle after an accept.
    tick();
    req_a[0 +: 64] = D3;
    req_b[0 +: 64] = D2;
    req_valid[0]   = 1'b1;
    wait_acc(0, "rst_acc");
    tick();
    rst_n = 1'b0;
    #1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_z", res_z, 0);
    chk("rst_idle", idle, 1);
    tick();
    req_valid[0] = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_no_spurious", res_valid, 0);
    end
    chk("rst_idle_after", idle, 1);

    // Fairness between requesters 1 and 3.
    tick();
    res_ready = '1;
    req_a     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_b     = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    req_valid = 4'b1010;
    last = 0;
    n1   = 0;
    n3   = 0;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (req_valid[1] && req_ready[1]) begin
        if (last != 0) chk("fair_alternate", last, 3);
        n1++;
        last = 1;
      end
      if (req_valid[3] && req_ready[3]) begin
        if (last != 0) chk("fair_alternate", last, 1);
        n3++;
        last = 3;
      end
      tick();
      req_a[64 +: 64]  = {$urandom, $urandom};
      req_b[64 +: 64]  = {$urandom, $urandom};
      req_a[192 +: 64] = {$urandom, $urandom};
      req_b[192 +: 64] = {$urandom, $urandom};
    end
    chk("fair_count_1", n1 >= 200, 1);
    chk("fair_count_3", n3 >= 200, 1);
    req_valid = '0;
    repeat (6) @(negedge clk);
    chk("final_idle", idle, 1);
    chk("scoreboard_empty", sb.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
